// File: rtl/serdes_pkg.sv
// Shared types for the SERDES read-side FIFO drain path.
package serdes_pkg;

    localparam int unsigned DEF_LOGIC_SIZE = 8;

    typedef logic [1:0] skid_level_t;

    // Encodings equal the occupancy, so the state doubles as the level.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/skid_buffer_2.sv
// Two-entry skid buffer: absorbs the FIFO read latency so the stream keeps full rate.
module skid_buffer_2
    import serdes_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_LOGIC_SIZE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             capture,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output skid_level_t      level
);

    skid_state_t      state_q, state_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            EMPTY: begin
                if (capture) begin
                    head_d  = wdata;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (capture && !pop) begin
                    tail_d  = wdata;
                    state_d = TWO;
                end else if (!capture && pop) begin
                    state_d = EMPTY;
                end else if (capture && pop) begin
                    head_d = wdata;
                end
            end
            TWO: begin
                // The request rule upstream keeps capture low while full.
                if (pop) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign head  = head_q;
    assign level = state_q;

endmodule

// File: rtl/axis_fifo_reader.sv
// Drains the clock-crossing FIFO into an AXI-Stream master with fixed-length framing.
module axis_fifo_reader
    import serdes_pkg::*;
#(
    parameter int unsigned LOGIC_SIZE = DEF_LOGIC_SIZE,
    parameter int unsigned FRAME_LEN  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    output logic                  o_rr,
    input  logic [LOGIC_SIZE-1:0] i_rdata,
    input  logic                  i_rempty,
    output logic [LOGIC_SIZE-1:0] o_tdata,
    output logic                  o_tvalid,
    input  logic                  i_tready,
    output logic                  o_tlast,
    output logic                  o_frame_done,
    output logic [1:0]            o_level
);

    localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LastBeat = CNT_W'(FRAME_LEN - 1);

    skid_level_t           level;
    logic [LOGIC_SIZE-1:0] head;
    logic                  inflight_q;
    logic                  pop;
    logic                  accept;
    logic                  tlast;
    logic [2:0]            pending;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic                  frame_done_q;

    skid_buffer_2 #(
        .WIDTH (LOGIC_SIZE)
    ) u_skid (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .capture (inflight_q),
        .pop     (pop),
        .wdata   (i_rdata),
        .head    (head),
        .level   (level)
    );

    assign o_tvalid = (level != 2'd0);
    assign pop      = o_tvalid && i_tready;
    assign tlast    = o_tvalid && (beat_cnt_q == LastBeat);

    // Words that will occupy the buffer after this edge; pop implies level >= 1.
    assign pending  = {1'b0, level} + {2'b00, inflight_q} - {2'b00, pop};
    assign o_rr     = i_rst_n && (pending < 3'd2);
    assign accept   = o_rr && !i_rempty;

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (pop) begin
            if (beat_cnt_q == LastBeat) begin
                beat_cnt_d = '0;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            inflight_q   <= 1'b0;
            beat_cnt_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            inflight_q   <= accept;
            beat_cnt_q   <= beat_cnt_d;
            frame_done_q <= pop && tlast;
        end
    end

    assign o_tdata      = head;
    assign o_tlast      = tlast;
    assign o_frame_done = frame_done_q;
    assign o_level      = level;

endmodule

// File: tb/tb_axis_fifo_reader.sv
// Directed and random-stall bench for axis_fifo_reader with a 4-beat frame.
module tb_axis_fifo_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rr;
    logic [7:0] rdata;
    logic       rempty;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       frame_done;
    logic [1:0] level;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    logic       cap_pending;

    logic       s_rr, s_valid, s_last, s_done, s_pop, s_acc, s_ovf;
    logic [7:0] s_data;
    logic [1:0] s_level;

    always #5 clk = ~clk;

    axis_fifo_reader #(
        .LOGIC_SIZE (8),
        .FRAME_LEN  (4)
    ) u_dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .o_rr         (rr),
        .i_rdata      (rdata),
        .i_rempty     (rempty),
        .o_tdata      (tdata),
        .o_tvalid     (tvalid),
        .i_tready     (tready),
        .o_tlast      (tlast),
        .o_frame_done (frame_done),
        .o_level      (level)
    );

    // One clock: sample just after the negedge, then model the FIFO's one-cycle read latency.
    task automatic tick();
        rempty = (fifo_q.size() == 0);
        #1;
        s_rr    = rr;
        s_valid = tvalid;
        s_last  = tlast;
        s_done  = frame_done;
        s_data  = tdata;
        s_level = level;
        s_pop   = tvalid && tready;
        s_acc   = rr && !rempty;
        s_ovf   = cap_pending && (level == 2'd2);
        @(posedge clk);
        @(negedge clk);
        cap_pending = s_acc;
        if (s_acc) rdata = fifo_q.pop_front();
        else rdata = 8'hEE;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        tready = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic push_word(input logic [7:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        tready = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        push_word(8'h01);
        for (int t = 0; t < 3; t++) begin
            tick();
            n_checks++; if (s_rr !== 1'b0) $display("FAIL reset_rr t=%0d got %b want 0", t, s_rr); else n_pass++;
            if (t > 0) begin
                n_checks++; if (s_valid !== 1'b0) $display("FAIL reset_valid t=%0d got %b want 0", t, s_valid); else n_pass++;
                n_checks++; if (s_level !== 2'd0) $display("FAIL reset_level t=%0d got %0d want 0", t, s_level); else n_pass++;
                n_checks++; if (s_data !== 8'h00) $display("FAIL reset_tdata t=%0d got %h want 00", t, s_data); else n_pass++;
                n_checks++; if ({s_last, s_done} !== 2'b00) $display("FAIL reset_flags t=%0d got %b want 00", t, {s_last, s_done}); else n_pass++;
            end
        end
        rst_n = 1'b1;
        tick();
        n_checks++; if (s_rr !== 1'b1) $display("FAIL reset_release_rr got %b want 1", s_rr); else n_pass++;
    endtask

    task automatic test_streaming();
        int beats = 0;
        int t_last = -1;
        logic prev_end = 1'b0;
        logic [7:0] expd;
        do_reset();
        tready = 1'b1;
        for (int i = 0; i < 8; i++) push_word(8'(8'h10 + i));
        for (int t = 0; t < 14; t++) begin
            tick();
            if (t < 2) begin
                n_checks++; if (s_valid !== 1'b0) $display("FAIL stream_latency t=%0d valid got %b want 0", t, s_valid); else n_pass++;
            end
            if (t == 2) begin
                n_checks++; if (s_valid !== 1'b1) $display("FAIL stream_first_valid got %b want 1", s_valid); else n_pass++;
            end
            n_checks++; if (s_done !== prev_end) $display("FAIL stream_frame_done t=%0d got %b want %b", t, s_done, prev_end); else n_pass++;
            if (s_pop) begin
                expd = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                n_checks++; if (s_data !== expd) $display("FAIL stream_data beat=%0d got %h want %h", beats, s_data, expd); else n_pass++;
                n_checks++; if (s_last !== (beats % 4 == 3)) $display("FAIL stream_tlast beat=%0d got %b want %b", beats, s_last, beats % 4 == 3); else n_pass++;
                beats++;
                t_last = t;
            end
            prev_end = s_pop && s_last;
        end
        n_checks++; if (beats !== 8) $display("FAIL stream_beat_count got %0d want 8", beats); else n_pass++;
        n_checks++; if (t_last !== 9) $display("FAIL stream_last_cycle got %0d want 9", t_last); else n_pass++;
    endtask

    task automatic test_backpressure();
        int beats = 0;
        int guard = 0;
        logic [7:0] expd;
        do_reset();
        tready = 1'b1;
        for (int i = 0; i < 8; i++) push_word(8'(8'h10 + i));
        while (beats < 2 && guard < 20) begin
            tick();
            if (s_pop) begin beats++; void'(exp_q.pop_front()); end
            guard++;
        end
        n_checks++; if (beats !== 2) $display("FAIL bp_prefix got %0d beats want 2", beats); else n_pass++;
        tready = 1'b0;
        for (int t = 0; t < 5; t++) begin
            tick();
            n_checks++; if ({s_valid, s_data} !== {1'b1, 8'h12}) $display("FAIL bp_hold t=%0d got %b/%h want 1/12", t, s_valid, s_data); else n_pass++;
        end
        n_checks++; if (s_level !== 2'd2) $display("FAIL bp_level got %0d want 2", s_level); else n_pass++;
        n_checks++; if (s_rr !== 1'b0) $display("FAIL bp_rr got %b want 0", s_rr); else n_pass++;
        tready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            tick();
            expd = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            n_checks++; if ({s_pop, s_data} !== {1'b1, expd}) $display("FAIL bp_resume t=%0d got %b/%h want 1/%h", t, s_pop, s_data, expd); else n_pass++;
            n_checks++; if (s_last !== (t == 1 || t == 5)) $display("FAIL bp_tlast t=%0d got %b want %b", t, s_last, t == 1 || t == 5); else n_pass++;
        end
        tick();
        n_checks++; if (s_valid !== 1'b0) $display("FAIL bp_drained got %b want 0", s_valid); else n_pass++;
    endtask

    task automatic test_empty_mid_stream();
        do_reset();
        tready = 1'b1;
        push_word(8'hA0);
        push_word(8'hA1);
        for (int t = 0; t < 11; t++) begin
            if (t == 6) begin
                push_word(8'hA2);
                push_word(8'hA3);
            end
            tick();
            case (t)
                2: begin n_checks++; if ({s_valid, s_data, s_last} !== {1'b1, 8'hA0, 1'b0}) $display("FAIL empty_a0 got %b/%h/%b want 1/a0/0", s_valid, s_data, s_last); else n_pass++; end
                3: begin n_checks++; if ({s_valid, s_data, s_last} !== {1'b1, 8'hA1, 1'b0}) $display("FAIL empty_a1 got %b/%h/%b want 1/a1/0", s_valid, s_data, s_last); else n_pass++; end
                4, 5, 6, 7: begin n_checks++; if (s_valid !== 1'b0) $display("FAIL empty_gap t=%0d valid got %b want 0", t, s_valid); else n_pass++; end
                8: begin n_checks++; if ({s_valid, s_data, s_last} !== {1'b1, 8'hA2, 1'b0}) $display("FAIL empty_a2 got %b/%h/%b want 1/a2/0", s_valid, s_data, s_last); else n_pass++; end
                9: begin n_checks++; if ({s_valid, s_data, s_last} !== {1'b1, 8'hA3, 1'b1}) $display("FAIL empty_a3 got %b/%h/%b want 1/a3/1", s_valid, s_data, s_last); else n_pass++; end
                10: begin n_checks++; if (s_done !== 1'b1) $display("FAIL empty_frame_done got %b want 1", s_done); else n_pass++; end
                default: ;
            endcase
        end
    endtask

    task automatic test_random_stall();
        int beats = 0;
        int ovf = 0;
        int done_err = 0;
        logic prev_end = 1'b0;
        logic [7:0] expd;
        do_reset();
        for (int i = 0; i < 1000; i++) push_word(8'($urandom));
        for (int t = 0; t < 5000 && beats < 1000; t++) begin
            tready = 1'($urandom_range(0, 1));
            tick();
            if (s_ovf) ovf++;
            if (s_done !== prev_end) done_err++;
            if (s_pop) begin
                expd = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                n_checks++; if (s_data !== expd) $display("FAIL rand_data beat=%0d got %h want %h", beats, s_data, expd); else n_pass++;
                n_checks++; if (s_last !== (beats % 4 == 3)) $display("FAIL rand_tlast beat=%0d got %b want %b", beats, s_last, beats % 4 == 3); else n_pass++;
                beats++;
            end
            prev_end = s_pop && s_last;
        end
        n_checks++; if (beats !== 1000) $display("FAIL rand_beat_count got %0d want 1000", beats); else n_pass++;
        n_checks++; if (ovf !== 0) $display("FAIL rand_capture_in_two got %0d want 0", ovf); else n_pass++;
        n_checks++; if (done_err !== 0) $display("FAIL rand_frame_done got %0d errors want 0", done_err); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int beats = 0;
        int guard = 0;
        int t_first = -1;
        logic [7:0] expd;
        do_reset();
        tready = 1'b1;
        for (int i = 0; i < 16; i++) push_word(8'(8'h30 + i));
        while (beats < 3 && guard < 20) begin
            tick();
            if (s_pop) beats++;
            guard++;
        end
        tready = 1'b0;
        tick();
        tick();
        n_checks++; if (s_level !== 2'd2) $display("FAIL rmid_level got %0d want 2", s_level); else n_pass++;
        rst_n = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        tick();
        tick();
        n_checks++; if ({s_rr, s_valid, s_last, s_done, s_level, s_data} !== 13'd0) $display("FAIL rmid_outputs got %b%b%b%b/%0d/%h want all zero", s_rr, s_valid, s_last, s_done, s_level, s_data); else n_pass++;
        rst_n  = 1'b1;
        tready = 1'b1;
        for (int i = 0; i < 4; i++) push_word(8'(8'h50 + i));
        beats = 0;
        for (int t = 0; t < 8; t++) begin
            tick();
            if (s_pop) begin
                if (t_first < 0) t_first = t;
                expd = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                n_checks++; if ({s_data, s_last} !== {expd, beats == 3}) $display("FAIL rmid_beat=%0d got %h/%b want %h/%b", beats, s_data, s_last, expd, beats == 3); else n_pass++;
                beats++;
            end
        end
        n_checks++; if (t_first !== 2) $display("FAIL rmid_first_cycle got %0d want 2", t_first); else n_pass++;
        n_checks++; if (beats !== 4) $display("FAIL rmid_beat_count got %0d want 4", beats); else n_pass++;
    endtask

    initial begin
        rst_n       = 1'b0;
        tready      = 1'b0;
        rempty      = 1'b1;
        rdata       = 8'hEE;
        cap_pending = 1'b0;
        @(negedge clk);
        test_reset();
        test_streaming();
        test_backpressure();
        test_empty_mid_stream();
        test_random_stall();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
